// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply / multiply-accumulate / divide unit that
// owns the architectural HI and LO registers. An operation is accepted with a
// Start request while idle, runs one shift-add or restoring-divide step per
// cycle on operand magnitudes, then spends one FINISH cycle restoring signs,
// accumulating and writing HI/LO. MTHI/MTLO bypass the iterative engine.

module mul_div_unit #(
   parameter int WIDTH = 32,
   parameter int CW    = 6
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [2:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic             DivZero,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_MADD  = 3'b010;
   localparam logic [2:0] OP_MSUB  = 3'b011;
   localparam logic [2:0] OP_DIV   = 3'b100;
   localparam logic [2:0] OP_DIVU  = 3'b101;
   localparam logic [2:0] OP_MTHI  = 3'b110;
   localparam logic [2:0] OP_MTLO  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FINISH
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [CW-1:0]      r_count;
   logic [2:0]         r_op;
   logic [WIDTH-1:0]   r_rawA;
   logic [WIDTH-1:0]   r_opnd;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [2*WIDTH-1:0] r_snap;
   logic               r_negP;
   logic               r_negR;
   logic               r_bZero;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;
   logic               r_divzero;

   logic               w_accept;
   logic               w_move;
   logic               w_signed;
   logic               w_isDiv;
   logic               w_negA;
   logic               w_negB;
   logic [WIDTH-1:0]   w_magA;
   logic [WIDTH-1:0]   w_magB;
   logic               w_lastIter;
   logic [WIDTH:0]     w_mulSum;
   logic [WIDTH:0]     w_divShift;
   logic               w_divGe;
   logic [WIDTH-1:0]   w_divDiff;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_sprod;
   logic [WIDTH-1:0]   w_resHi;
   logic [WIDTH-1:0]   w_resLo;

   // Request decode and operand magnitudes; a signed operand is negated so the
   // iterative engine only ever works on unsigned values. The most-negative
   // value negates to itself, which is its correct unsigned magnitude.
   always_comb begin
      w_accept   = (r_state == ST_IDLE) && Start && (Op != OP_MTHI) && (Op != OP_MTLO);
      w_move     = (r_state == ST_IDLE) && Start && ((Op == OP_MTHI) || (Op == OP_MTLO));
      w_signed   = (Op == OP_MULT) || (Op == OP_MADD) || (Op == OP_MSUB) || (Op == OP_DIV);
      w_isDiv    = (Op == OP_DIV) || (Op == OP_DIVU);
      w_negA     = w_signed && A[WIDTH-1];
      w_negB     = w_signed && B[WIDTH-1];
      w_magA     = w_negA ? -A : A;
      w_magB     = w_negB ? -B : B;
      w_lastIter = (r_count == CW'(WIDTH - 1));
   end

   // One iteration step: shift-add for multiply (r_quo holds the multiplier
   // being consumed from the bottom) and restoring divide (r_quo holds the
   // dividend being consumed from the top while quotient bits enter below).
   always_comb begin
      w_mulSum   = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_opnd} : '0);
      w_divShift = {r_rem, r_quo[WIDTH-1]};
      w_divGe    = (w_divShift >= {1'b0, r_opnd});
      w_divDiff  = w_divShift[WIDTH-1:0] - r_opnd;
   end

   // Final result: restore signs, then accumulate or pick quotient/remainder.
   // Divide by zero yields all-ones quotient and the raw dividend as remainder.
   always_comb begin
      w_prod  = {r_rem, r_quo};
      w_sprod = r_negP ? -w_prod : w_prod;
      w_resHi = r_hi;
      w_resLo = r_lo;
      case (r_op)
         OP_MULT, OP_MULTU: {w_resHi, w_resLo} = w_sprod;
         OP_MADD:           {w_resHi, w_resLo} = r_snap + w_sprod;
         OP_MSUB:           {w_resHi, w_resLo} = r_snap - w_sprod;
         OP_DIV, OP_DIVU: begin
            if (r_bZero) begin
               w_resHi = r_rawA;
               w_resLo = '1;
            end else begin
               w_resHi = r_negR ? -r_rem : r_rem;
               w_resLo = r_negP ? -r_quo : r_quo;
            end
         end
         default: begin
            w_resHi = r_hi;
            w_resLo = r_lo;
         end
      endcase
   end

   // State register.
   always_ff @(posedge Clk) begin
      if (Reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic: IDLE -> RUN on an iterative request, RUN for WIDTH
   // cycles, then a single FINISH cycle back to IDLE.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_accept) w_next = ST_RUN;
         ST_RUN:    if (w_lastIter) w_next = ST_FINISH;
         ST_FINISH: w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // Datapath: latch operands on acceptance, iterate during RUN, commit HI/LO
   // on the FINISH exit edge or on a move. Done/DivZero are one-cycle pulses.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_count   <= '0;
         r_op      <= OP_MULT;
         r_rawA    <= '0;
         r_opnd    <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_snap    <= '0;
         r_negP    <= 1'b0;
         r_negR    <= 1'b0;
         r_bZero   <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_done    <= 1'b0;
         r_divzero <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_divzero <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_op    <= Op;
                  r_rawA  <= A;
                  r_snap  <= {r_hi, r_lo};
                  r_opnd  <= w_isDiv ? w_magB : w_magA;
                  r_quo   <= w_isDiv ? w_magA : w_magB;
                  r_rem   <= '0;
                  r_negP  <= w_negA ^ w_negB;
                  r_negR  <= w_negA;
                  r_bZero <= (B == '0);
                  r_count <= '0;
               end else if (w_move) begin
                  if (Op == OP_MTHI) r_hi <= A;
                  else               r_lo <= A;
                  r_done <= 1'b1;
               end
            end
            ST_RUN: begin
               if ((r_op == OP_DIV) || (r_op == OP_DIVU)) begin
                  r_rem <= w_divGe ? w_divDiff : w_divShift[WIDTH-1:0];
                  r_quo <= {r_quo[WIDTH-2:0], w_divGe};
               end else begin
                  r_rem <= w_mulSum[WIDTH:1];
                  r_quo <= {w_mulSum[0], r_quo[WIDTH-1:1]};
               end
               r_count <= w_lastIter ? '0 : r_count + CW'(1);
            end
            ST_FINISH: begin
               r_hi      <= w_resHi;
               r_lo      <= w_resLo;
               r_done    <= 1'b1;
               r_divzero <= r_bZero && ((r_op == OP_DIV) || (r_op == OP_DIVU));
               r_count   <= '0;
            end
            default: r_count <= '0;
         endcase
      end
   end

   assign Busy    = (r_state != ST_IDLE);
   assign Done    = r_done;
   assign DivZero = r_divzero;
   assign HI      = r_hi;
   assign LO      = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: table-driven directed vectors for mul_div_unit with
// hand-computed results, plus hand-written back-to-back and abort sequences.

module tb_mul_div_unit;

   localparam int WIDTH = 32;
   localparam int NV    = 16;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_MADD  = 3'b010;
   localparam logic [2:0] OP_MSUB  = 3'b011;
   localparam logic [2:0] OP_DIV   = 3'b100;
   localparam logic [2:0] OP_DIVU  = 3'b101;
   localparam logic [2:0] OP_MTHI  = 3'b110;
   localparam logic [2:0] OP_MTLO  = 3'b111;

   logic             Clk;
   logic             Reset;
   logic             Start;
   logic [2:0]       Op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Busy;
   logic             Done;
   logic             DivZero;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expHi;
      logic [31:0] expLo;
      logic        expDz;
   } vec_t;

   vec_t vecs [NV];

   int checks   = 0;
   int failures = 0;

   mul_div_unit #(.WIDTH(WIDTH), .CW(6)) dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .Start   (Start),
      .Op      (Op),
      .A       (A),
      .B       (B),
      .Busy    (Busy),
      .Done    (Done),
      .DivZero (DivZero),
      .HI      (HI),
      .LO      (LO)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Compare one observed value against the expected value.
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   // Issue one request just after a clock edge, scramble the operand inputs
   // once it is accepted, and wait (bounded) for Done. lat counts edges from
   // the accepting edge inclusive up to the edge after which Done is seen.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output int lat, output bit sawBusy);
      Start = 1'b1;
      Op    = op;
      A     = a;
      B     = b;
      @(posedge Clk);
      #1;
      Start   = 1'b0;
      A       = $urandom;
      B       = $urandom;
      Op      = 3'(op + 3'd1);
      lat     = 1;
      sawBusy = Busy;
      while (!Done && lat < 200) begin
         @(posedge Clk);
         #1;
         lat++;
         if (Busy) sawBusy = 1'b1;
      end
   endtask

   // Main test sequence.
   initial begin
      int  lat;
      bit  sawBusy;
      bit  isMove;
      bit  doneSeen;

      Reset = 1'b1;
      Start = 1'b0;
      Op    = OP_MULT;
      A     = '0;
      B     = '0;

      vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      vecs[2]  = '{OP_MSUB,  32'h00000002, 32'h00000003, 32'hFFFFFFFD, 32'hFFFFFFFB, 1'b0};
      vecs[3]  = '{OP_MTHI,  32'h00000000, 32'h12345678, 32'h00000000, 32'hFFFFFFFB, 1'b0};
      vecs[4]  = '{OP_MTLO,  32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0};
      vecs[5]  = '{OP_MADD,  32'h00000001, 32'h00000001, 32'h00000001, 32'h00000000, 1'b0};
      vecs[6]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[7]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      vecs[8]  = '{OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
      vecs[9]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
      vecs[10] = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
      vecs[11] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
      vecs[12] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
      vecs[13] = '{OP_MADD,  32'hFFFFFFFF, 32'h00000005, 32'h3FFFFFFF, 32'hFFFFFFFB, 1'b0};
      vecs[14] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
      vecs[15] = '{OP_MSUB,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b0};

      repeat (2) @(posedge Clk);
      #1;
      checkOutput("reset_hi",      64'(HI),      64'd0);
      checkOutput("reset_lo",      64'(LO),      64'd0);
      checkOutput("reset_busy",    64'(Busy),    64'd0);
      checkOutput("reset_done",    64'(Done),    64'd0);
      checkOutput("reset_divzero", 64'(DivZero), 64'd0);
      Reset = 1'b0;
      @(posedge Clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat, sawBusy);
         isMove = (vecs[i].op == OP_MTHI) || (vecs[i].op == OP_MTLO);
         checkOutput($sformatf("v%0d_latency", i), 64'(lat), isMove ? 64'd1 : 64'(WIDTH + 2));
         checkOutput($sformatf("v%0d_busyseen", i), 64'(sawBusy), isMove ? 64'd0 : 64'd1);
         checkOutput($sformatf("v%0d_busy_at_done", i), 64'(Busy), 64'd0);
         checkOutput($sformatf("v%0d_hi", i), 64'(HI), 64'(vecs[i].expHi));
         checkOutput($sformatf("v%0d_lo", i), 64'(LO), 64'(vecs[i].expLo));
         checkOutput($sformatf("v%0d_divzero", i), 64'(DivZero), 64'(vecs[i].expDz));
      end

      // Done and DivZero are single-cycle pulses.
      @(posedge Clk);
      #1;
      checkOutput("done_pulse_width",    64'(Done),    64'd0);
      checkOutput("divzero_pulse_width", 64'(DivZero), 64'd0);

      // Back-to-back: the second request is issued in the Done cycle.
      applyStimulus(OP_MULTU, 32'd3, 32'd4, lat, sawBusy);
      checkOutput("b2b_first_latency", 64'(lat), 64'(WIDTH + 2));
      checkOutput("b2b_first_hi", 64'(HI), 64'd0);
      checkOutput("b2b_first_lo", 64'(LO), 64'd12);
      applyStimulus(OP_DIVU, 32'd12, 32'd5, lat, sawBusy);
      checkOutput("b2b_second_latency", 64'(lat), 64'(WIDTH + 2));
      checkOutput("b2b_second_hi", 64'(HI), 64'd2);
      checkOutput("b2b_second_lo", 64'(LO), 64'd2);

      // Abort: MULT in flight, MTHI request ignored, then Reset mid-run.
      Start = 1'b1;
      Op    = OP_MULT;
      A     = 32'd3;
      B     = 32'd5;
      doneSeen = 1'b0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         @(posedge Clk);
         #1;
         if (Done) doneSeen = 1'b1;
         Start = 1'b0;
         Reset = 1'b0;
         if (cyc == 4) begin
            Start = 1'b1;
            Op    = OP_MTHI;
            A     = 32'h00001234;
         end
         if (cyc == 6) begin
            checkOutput("abort_mthi_ignored_hi", 64'(HI), 64'd2);
            checkOutput("abort_busy_midrun",     64'(Busy), 64'd1);
         end
         if (cyc == 9) Reset = 1'b1;
         if (cyc == 10) begin
            checkOutput("abort_busy", 64'(Busy), 64'd0);
            checkOutput("abort_hi",   64'(HI),   64'd0);
            checkOutput("abort_lo",   64'(LO),   64'd0);
            checkOutput("abort_done", 64'(Done), 64'd0);
         end
      end
      checkOutput("abort_no_done_pulse", 64'(doneSeen), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
